// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared types and constants for the instruction-fetch front end.
//             - fetch_entry_t : one prefetched word tagged with its PC
//             - fetch_state_t : fetch sequencer states
//             - NOP           : canonical no-op encoding
//             - align_pc()    : forces a PC onto a word boundary
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : Small power-of-two FIFO holding prefetched entries. The head
//             entry is visible combinationally. Flush has priority over
//             push and pop; push is ignored when full, pop when empty.
//  Ports    : clk, rst_n     - clock, asynchronous active-low reset
//             flush_i        - discard all entries
//             push_i/data_i  - enqueue one entry
//             pop_i          - dequeue the head entry
//             full_o/empty_o - occupancy flags
//             count_o        - number of stored entries
//             head_o         - oldest entry (undefined when empty)
//  Revision : 1.0  initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  T                         data_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output T                         head_o
);

    localparam int                   c_PTR_W   = $clog2(DEPTH);
    localparam int                   c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]   c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);

    T                     mem_q [DEPTH];
    logic [c_PTR_W-1:0]   wr_ptr_q;
    logic [c_PTR_W-1:0]   rd_ptr_q;
    logic [c_CNT_W-1:0]   count_q;
    logic                 w_push;
    logic                 w_pop;

    assign full_o  = (count_q == c_DEPTH);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign w_push = push_i && !full_o  && !flush_i;
    assign w_pop  = pop_i  && !empty_o && !flush_i;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + c_CNT_ONE;
                2'b01:   count_q <= count_q - c_CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed once counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_prefetch_unit
//  Purpose  : Instruction-fetch front end. Issues sequential word reads on
//             the I-side memory port (one outstanding read, no back-to-back
//             requests), queues returned words tagged with their PC and
//             presents them to decode over valid/ready. A redirect flushes
//             the queue and restarts fetch at a new PC.
//  Ports    : clk, rst_n                  - clock, async active-low reset
//             redirect_valid, redirect_pc - fetch redirect request
//             imem_addr, imem_read        - registered I-port request
//             imem_rdata, imem_resp       - I-port response
//             out_valid, out_ready        - decode handshake
//             out_instr, out_pc           - queue head (0 when empty)
//  Revision : 1.0  initial release
// ============================================================================
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int                 c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [31:0]        c_WORD  = 32'd4;

    fetch_state_t        state_q;
    logic [31:0]         pc_q;
    logic [31:0]         imem_addr_q;
    logic                imem_read_q;
    logic                discard_q;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [c_CNT_W-1:0]  w_count;
    logic                w_can_issue;
    fetch_entry_t        w_push_entry;
    fetch_entry_t        w_head;

    // Issue only in IDLE, where nothing is outstanding, so a free slot now
    // guarantees room for the response.
    assign w_can_issue = (w_count < c_DEPTH);

    // A redirect on the response cycle kills the word; a pending discard
    // kills the stale response of a request issued before a redirect.
    assign w_push = (state_q == REQ) && imem_resp && !discard_q
                    && !redirect_valid && !w_full;

    // Redirect wins over dequeue: the head is flushed, not consumed.
    assign w_pop  = out_valid && out_ready && !redirect_valid;

    assign w_push_entry.pc    = imem_addr_q;
    assign w_push_entry.instr = imem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            imem_addr_q <= RESET_PC;
            imem_read_q <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_valid) begin
                        pc_q <= align_pc(redirect_pc);
                    end else if (w_can_issue) begin
                        imem_read_q <= 1'b1;
                        imem_addr_q <= pc_q;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (imem_resp) begin
                        imem_read_q <= 1'b0;
                        discard_q   <= 1'b0;
                        state_q     <= IDLE;
                        if (redirect_valid) begin
                            pc_q <= align_pc(redirect_pc);
                        end else if (!discard_q) begin
                            pc_q <= imem_addr_q + c_WORD;
                        end
                    end else if (redirect_valid) begin
                        // The read cannot be withdrawn; hold it and drop
                        // its data when it finally returns.
                        discard_q <= 1'b1;
                        pc_q      <= align_pc(redirect_pc);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    imem_read_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (w_push),
        .data_i  (w_push_entry),
        .pop_i   (w_pop),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count),
        .head_o  (w_head)
    );

    assign imem_addr = imem_addr_q;
    assign imem_read = imem_read_q;
    assign out_valid = !w_empty;
    assign out_pc    = w_empty ? 32'h0 : w_head.pc;
    assign out_instr = w_empty ? 32'h0 : w_head.instr;

endmodule : fetch_prefetch_unit
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_prefetch_unit
//  Purpose  : Directed self-checking bench for fetch_prefetch_unit. A memory
//             model with selectable latency returns word A ^ 32'hA5A5_0000.
//             Monitors log issued reads and accepted queue heads.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_prefetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h4000_0000;
    localparam logic [31:0] c_SALT     = 32'hA5A5_0000;
    localparam logic [31:0] c_NONE     = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_resp = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int          n_vec = 0;
    int          n_err = 0;
    int          mem_lat = 1;
    int          wcnt = 0;
    int          cyc = 0;
    int          proto_err = 0;
    logic        read_last = 1'b0;
    logic        resp_last = 1'b0;

    logic [31:0] iss_addr [$];
    int          iss_cyc  [$];
    logic [31:0] pop_pc   [$];
    logic [31:0] pop_ins  [$];
    int          iss_base = 0;
    int          pop_base = 0;

    fetch_prefetch_unit #(
        .RESET_PC (c_RESET_PC),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_read      (imem_read),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    // Memory: responds mem_lat cycles after read rises, updated on negedge.
    always @(negedge clk) begin
        if (imem_read) begin
            if (wcnt + 1 == mem_lat) begin
                imem_resp  <= 1'b1;
                imem_rdata <= imem_addr ^ c_SALT;
                wcnt       <= 0;
            end else begin
                imem_resp  <= 1'b0;
                wcnt       <= wcnt + 1;
            end
        end else begin
            imem_resp <= 1'b0;
            wcnt      <= 0;
        end
    end

    // Observes pre-edge values: issued reads, accepted heads, protocol.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (imem_read && !read_last) begin
                iss_addr.push_back(imem_addr);
                iss_cyc.push_back(cyc);
            end
            if (resp_last && imem_read) begin
                proto_err <= proto_err + 1;
            end
            if (out_valid && out_ready && !redirect_valid) begin
                pop_pc.push_back(out_pc);
                pop_ins.push_back(out_instr);
            end
        end
        read_last <= imem_read;
        resp_last <= imem_resp;
    end

    task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] iss_at(input int i);
        if (iss_base + i < iss_addr.size()) return iss_addr[iss_base + i];
        return c_NONE;
    endfunction

    function automatic logic [31:0] gap_at(input int i);
        if (iss_base + i < iss_cyc.size())
            return 32'(iss_cyc[iss_base + i] - iss_cyc[iss_base + i - 1]);
        return c_NONE;
    endfunction

    function automatic logic [31:0] pc_at(input int i);
        if (pop_base + i < pop_pc.size()) return pop_pc[pop_base + i];
        return c_NONE;
    endfunction

    function automatic logic [31:0] ins_at(input int i);
        if (pop_base + i < pop_ins.size()) return pop_ins[pop_base + i];
        return c_NONE;
    endfunction

    // Holds reset two cycles, checks reset outputs, releases on a negedge.
    task automatic do_reset(input int lat, input logic rdy);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        mem_lat        = lat;
        repeat (2) @(negedge clk);
        chk_vec("rst_valid", 32'(out_valid), 32'd0);
        chk_vec("rst_read",  32'(imem_read), 32'd0);
        chk_vec("rst_addr",  imem_addr,      c_RESET_PC);
        chk_vec("rst_pc",    out_pc,         32'h0);
        iss_base  = iss_addr.size();
        pop_base  = pop_pc.size();
        out_ready = rdy;
        rst_n     = 1'b1;
    endtask

    initial begin
        // 1: streaming with a 1-cycle memory
        do_reset(1, 1'b1);
        repeat (12) @(negedge clk);
        chk_vec("t1_iss0", iss_at(0), 32'h4000_0000);
        chk_vec("t1_iss1", iss_at(1), 32'h4000_0004);
        chk_vec("t1_iss2", iss_at(2), 32'h4000_0008);
        chk_vec("t1_gap1", gap_at(1), 32'd2);
        chk_vec("t1_gap2", gap_at(2), 32'd2);
        chk_vec("t1_pc0",  pc_at(0),  32'h4000_0000);
        chk_vec("t1_in0",  ins_at(0), 32'hE5A5_0000);
        chk_vec("t1_pc1",  pc_at(1),  32'h4000_0004);
        chk_vec("t1_pc2",  pc_at(2),  32'h4000_0008);
        chk_vec("t1_in2",  ins_at(2), 32'hE5A5_0008);

        // 2: backpressure fills the queue, then drains
        do_reset(1, 1'b0);
        repeat (20) @(negedge clk);
        chk_vec("t2_nissue", 32'(iss_addr.size() - iss_base), 32'd4);
        chk_vec("t2_read",   32'(imem_read), 32'd0);
        chk_vec("t2_valid",  32'(out_valid), 32'd1);
        chk_vec("t2_head",   out_pc,         32'h4000_0000);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk_vec("t2_npop", 32'(pop_pc.size() - pop_base), 32'd4);
        chk_vec("t2_pc1",  pc_at(1), 32'h4000_0004);
        chk_vec("t2_pc3",  pc_at(3), 32'h4000_000C);
        repeat (4) @(negedge clk);
        chk_vec("t2_iss4", iss_at(4), 32'h4000_0010);
        chk_vec("t2_pc4",  pc_at(4),  32'h4000_0010);

        // 3: redirect while a 3-cycle read is pending
        do_reset(3, 1'b1);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000_0101;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk_vec("t3_hold_rd", 32'(imem_read), 32'd1);
        chk_vec("t3_hold_ad", imem_addr,      32'h4000_0000);
        repeat (20) @(negedge clk);
        chk_vec("t3_iss1", iss_at(1), 32'h4000_0100);
        chk_vec("t3_pc0",  pc_at(0),  32'h4000_0100);
        chk_vec("t3_in0",  ins_at(0), 32'hE5A5_0100);

        // 4: redirect on the response cycle while the head is accepted
        do_reset(1, 1'b0);
        repeat (3) @(negedge clk);
        chk_vec("t4_pre_v",  32'(out_valid), 32'd1);
        chk_vec("t4_pre_ad", imem_addr,      32'h4000_0004);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000_0200;
        out_ready      = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk_vec("t4_flush", 32'(out_valid), 32'd0);
        chk_vec("t4_npop0", 32'(pop_pc.size() - pop_base), 32'd0);
        repeat (8) @(negedge clk);
        chk_vec("t4_iss2", iss_at(2), 32'h4000_0200);
        chk_vec("t4_pc0",  pc_at(0),  32'h4000_0200);
        chk_vec("t4_in0",  ins_at(0), 32'hE5A5_0200);
        chk_vec("t4_pc1",  pc_at(1),  32'h4000_0204);

        // 5: PC wraps past the top of the address space
        do_reset(1, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk_vec("t5_iss0", iss_at(0), 32'hFFFF_FFF8);
        chk_vec("t5_pc0",  pc_at(0),  32'hFFFF_FFF8);
        chk_vec("t5_in0",  ins_at(0), 32'h5A5A_FFF8);
        chk_vec("t5_pc1",  pc_at(1),  32'hFFFF_FFFC);
        chk_vec("t5_pc2",  pc_at(2),  32'h0000_0000);
        chk_vec("t5_in2",  ins_at(2), 32'hA5A5_0000);

        // 6: asynchronous reset with two queued entries and a read pending
        do_reset(1, 1'b0);
        repeat (5) @(negedge clk);
        chk_vec("t6_pre_rd", 32'(imem_read), 32'd1);
        chk_vec("t6_pre_ad", imem_addr,      32'h4000_0008);
        rst_n = 1'b0;
        #1;
        chk_vec("t6_valid", 32'(out_valid), 32'd0);
        chk_vec("t6_read",  32'(imem_read), 32'd0);
        chk_vec("t6_addr",  imem_addr,      c_RESET_PC);
        do_reset(1, 1'b0);
        repeat (3) @(negedge clk);
        chk_vec("t6_iss0", iss_at(0), c_RESET_PC);

        chk_vec("proto_hold", 32'(proto_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fetch_prefetch_unit
`default_nettype wire
